// File: rtl/bram_stream_pkg.sv
// Shared types for the BRAM stream reader: FSM state encoding and
// address/length helpers sized for the default 1024-word cache BRAM.
package bram_stream_pkg;

  localparam int DEFAULT_DEPTH      = 1024;
  localparam int DEFAULT_NBITS_ADDR = $clog2(DEFAULT_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Word address into the BRAM.
  typedef logic [DEFAULT_NBITS_ADDR-1:0] addr_t;
  // Word count; one extra bit so a full-BRAM run (DEPTH words) fits.
  typedef logic [DEFAULT_NBITS_ADDR:0]   len_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO holding BRAM words until the stream consumer takes them.
// The head entry is presented combinationally on dout; storage resets to zero so
// dout reads 0 while empty after reset.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next pointer and occupancy; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= din;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a contiguous run of BRAM words and streams them out over valid/ready.
// Reads are only issued when a FIFO slot is guaranteed for the returning word,
// which hides the BRAM's one-cycle read latency without dropping data.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int WIDTH_BITS = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int NBITS_ADDR = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NBITS_ADDR-1:0] base_addr,
  input  logic [NBITS_ADDR:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_read_en,
  output logic [NBITS_ADDR-1:0] bram_addr_read,
  input  logic [WIDTH_BITS-1:0] bram_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH_BITS-1:0] m_data,
  output logic                  m_last
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]           CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);
  localparam logic [NBITS_ADDR-1:0] ADDR_LAST  = NBITS_ADDR'(DEPTH - 1);
  localparam logic [NBITS_ADDR-1:0] ADDR_ONE   = NBITS_ADDR'(1);
  localparam logic [NBITS_ADDR:0]   LEN_ONE    = (NBITS_ADDR + 1)'(1);

  state_e                state_q;
  logic [NBITS_ADDR-1:0] addr_q, addr_d;
  logic [NBITS_ADDR:0]   issue_cnt_q;
  logic [NBITS_ADDR:0]   beat_cnt_q;
  logic                  inflight_q;
  logic                  done_q;

  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  pop;
  logic [CW:0]           credit_sum;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  // Slots already spoken for: stored words plus one in flight, minus the one leaving now.
  assign credit_sum = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

  // Issue a read only when the returning word is certain to have a FIFO slot.
  assign bram_read_en   = (state_q == RUN) && (issue_cnt_q != '0) && (credit_sum < CREDIT_MAX);
  assign bram_addr_read = addr_q;
  assign addr_d         = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;

  assign m_last = m_valid && (beat_cnt_q == LEN_ONE);
  assign busy   = (state_q != IDLE);
  assign done   = done_q;

  // Sequencer: launch, read issue, drain to the final beat, completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= bram_read_en;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= RUN;
              addr_q      <= base_addr;
              issue_cnt_q <= length;
              beat_cnt_q  <= length;
            end
          end
        end
        RUN: begin
          if (pop) beat_cnt_q <= beat_cnt_q - LEN_ONE;
          if (bram_read_en) begin
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_q - LEN_ONE;
            if (issue_cnt_q == LEN_ONE) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop) begin
            beat_cnt_q <= beat_cnt_q - LEN_ONE;
            if (m_last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   (bram_data_out),
    .dout  (m_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  localparam int DEPTH = 1024;
  localparam int W     = 32;
  localparam int AW    = 10;
  localparam int FD    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, bram_read_en, m_valid, m_last;
  logic [AW-1:0] bram_addr_read;
  logic [W-1:0]  bram_data_out = '0;
  logic          m_ready = 1'b1;
  logic [W-1:0]  m_data;

  logic [W-1:0]  ram [DEPTH];

  int tests_run = 0;
  int tests_failed = 0;

  int           got_addr[$];
  logic [W-1:0] got_data[$];
  bit           got_last[$];
  int           done_cycle, first_read, first_valid;
  int           stab_err, credit_err;
  bit           busy_seen;
  int           inj_cycle = -1;
  bit           chain_en = 1'b0;
  int           chain_base, chain_len;

  bit rdy_pat [16] = '{1,0,0,1,1,0,1,0,0,0,1,1,0,1,1,0};

  bram_stream_reader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .bram_read_en   (bram_read_en),
    .bram_addr_read (bram_addr_read),
    .bram_data_out  (bram_data_out),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last)
  );

  always #5 clk = ~clk;

  // Registered-read BRAM model.
  always @(posedge clk) if (bram_read_en) bram_data_out <= ram[bram_addr_read];

  // Runs one transfer, observing each cycle at negedge+1. Cycle 0 is the start cycle.
  task automatic run_collect(input int base, input int len, input bit stall, input int budget,
                             input bit launch);
    int occ = 0;
    bit infl = 1'b0;
    bit pop;
    bit pv_hold = 1'b0;
    logic [W-1:0] pv_data = '0;
    got_addr.delete(); got_data.delete(); got_last.delete();
    done_cycle = -1; first_read = -1; first_valid = -1;
    stab_err = 0; credit_err = 0; busy_seen = 1'b0;
    if (launch) begin
      @(negedge clk);
      base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1; m_ready = 1'b1;
    end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = (c == inj_cycle);
      if (c == inj_cycle) begin base_addr = AW'(500); length = (AW+1)'(2); end
      m_ready = !stall ? 1'b1 : (c <= 16) ? rdy_pat[c-1] : 1'($urandom_range(0, 1));
      #1;
      pop = m_valid && m_ready;
      if (busy) busy_seen = 1'b1;
      if (pv_hold && (!m_valid || m_data !== pv_data)) stab_err++;
      if (m_valid !== (occ != 0)) credit_err++;
      if (bram_read_en && (occ + int'(infl) - int'(pop)) >= FD) credit_err++;
      if (occ > FD) credit_err++;
      if (bram_read_en) begin
        got_addr.push_back(int'(bram_addr_read));
        if (first_read < 0) first_read = c;
      end
      if (m_valid && first_valid < 0) first_valid = c;
      if (pop) begin got_data.push_back(m_data); got_last.push_back(m_last); end
      if (done) begin
        done_cycle = c;
        if (busy) busy_seen = 1'b1;
        if (chain_en) begin
          start = 1'b1; base_addr = AW'(chain_base); length = (AW+1)'(chain_len);
        end
        break;
      end
      pv_hold = m_valid && !m_ready;
      pv_data = m_data;
      occ = occ + int'(infl) - int'(pop);
      infl = bram_read_en;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
    tests_run++; if (bram_read_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rden got=%b exp=0", bram_read_en); end
    tests_run++; if (bram_addr_read !== '0) begin tests_failed++; $display("FAIL reset_addr got=%0d exp=0", bram_addr_read); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    tests_run++; if (m_data !== '0) begin tests_failed++; $display("FAIL reset_data got=%0h exp=0", m_data); end
    tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last got=%b exp=0", m_last); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    run_collect(4, 5, 1'b0, 20, 1'b1);
    tests_run++; if (first_read !== 1) begin tests_failed++; $display("FAIL basic_first_read got=%0d exp=1", first_read); end
    tests_run++; if (first_valid !== 3) begin tests_failed++; $display("FAIL basic_first_valid got=%0d exp=3", first_valid); end
    tests_run++; if (done_cycle !== 8) begin tests_failed++; $display("FAIL basic_done_cycle got=%0d exp=8", done_cycle); end
    tests_run++; if (got_data.size() !== 5) begin tests_failed++; $display("FAIL basic_beats got=%0d exp=5", got_data.size()); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= got_data.size() || got_data[i] !== W'(104 + i) || got_last[i] !== (i == 4) ||
          i >= got_addr.size() || got_addr[i] !== 4 + i) begin
        tests_failed++; $display("FAIL basic_beat%0d got_data=%0d exp=%0d", i,
                                 (i < got_data.size()) ? int'(got_data[i]) : -1, 104 + i);
      end
    end
    tests_run++; if (stab_err + credit_err !== 0) begin tests_failed++; $display("FAIL basic_protocol got=%0d exp=0", stab_err + credit_err); end
  endtask

  task automatic test_wrap;
    int exp_a [4] = '{DEPTH-2, DEPTH-1, 0, 1};
    int exp_d [4] = '{DEPTH-2+100, DEPTH-1+100, 100, 101};
    run_collect(DEPTH-2, 4, 1'b0, 20, 1'b1);
    tests_run++; if (got_addr.size() !== 4 || got_data.size() !== 4) begin tests_failed++; $display("FAIL wrap_count got=%0d exp=4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= got_addr.size() || got_addr[i] !== exp_a[i]) begin
        tests_failed++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, (i < got_addr.size()) ? got_addr[i] : -1, exp_a[i]);
      end
      tests_run++;
      if (i >= got_data.size() || got_data[i] !== W'(exp_d[i])) begin
        tests_failed++; $display("FAIL wrap_data%0d got=%0d exp=%0d", i, (i < got_data.size()) ? int'(got_data[i]) : -1, exp_d[i]);
      end
    end
    tests_run++; if (done_cycle !== 7) begin tests_failed++; $display("FAIL wrap_done_cycle got=%0d exp=7", done_cycle); end
  endtask

  task automatic test_stall;
    run_collect(10, 6, 1'b1, 300, 1'b1);
    tests_run++; if (done_cycle < 0) begin tests_failed++; $display("FAIL stall_timeout got=%0d exp=done", done_cycle); end
    tests_run++; if (got_data.size() !== 6) begin tests_failed++; $display("FAIL stall_beats got=%0d exp=6", got_data.size()); end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (i >= got_data.size() || got_data[i] !== W'(110 + i) || got_last[i] !== (i == 5)) begin
        tests_failed++; $display("FAIL stall_beat%0d got=%0d exp=%0d", i, (i < got_data.size()) ? int'(got_data[i]) : -1, 110 + i);
      end
    end
    tests_run++; if (got_addr.size() !== 6) begin tests_failed++; $display("FAIL stall_reads got=%0d exp=6", got_addr.size()); end
    tests_run++; if (stab_err !== 0) begin tests_failed++; $display("FAIL stall_stable got=%0d exp=0", stab_err); end
    tests_run++; if (credit_err !== 0) begin tests_failed++; $display("FAIL stall_credit got=%0d exp=0", credit_err); end
  endtask

  task automatic test_zero_len;
    run_collect(7, 0, 1'b0, 10, 1'b1);
    tests_run++; if (done_cycle !== 1) begin tests_failed++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cycle); end
    tests_run++; if (got_addr.size() !== 0) begin tests_failed++; $display("FAIL zero_reads got=%0d exp=0", got_addr.size()); end
    tests_run++; if (first_valid !== -1) begin tests_failed++; $display("FAIL zero_valid got=%0d exp=-1", first_valid); end
    tests_run++; if (busy_seen !== 1'b0) begin tests_failed++; $display("FAIL zero_busy got=%b exp=0", busy_seen); end
  endtask

  task automatic test_reset_mid;
    int pops = 0;
    int bad = 0;
    @(negedge clk);
    base_addr = AW'(20); length = (AW+1)'(8); start = 1'b1; m_ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (m_valid && m_ready) pops++;
      if (pops == 2) break;
    end
    tests_run++; if (pops !== 2) begin tests_failed++; $display("FAIL rstmid_prebeats got=%0d exp=2", pops); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, bram_read_en, m_valid, m_last} !== 5'b0 || bram_addr_read !== '0 || m_data !== '0) begin
      tests_failed++; $display("FAIL rstmid_outputs got=%b%b%b%b%b addr=%0d data=%0h exp=0",
                               busy, done, bram_read_en, m_valid, m_last, bram_addr_read, m_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (m_valid || bram_read_en || busy || done) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
    run_collect(0, 3, 1'b0, 20, 1'b1);
    tests_run++; if (got_data.size() !== 3) begin tests_failed++; $display("FAIL rstmid_beats got=%0d exp=3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= got_data.size() || got_data[i] !== W'(100 + i)) begin
        tests_failed++; $display("FAIL rstmid_data%0d got=%0d exp=%0d", i, (i < got_data.size()) ? int'(got_data[i]) : -1, 100 + i);
      end
    end
  endtask

  task automatic test_back_to_back;
    inj_cycle = 2; chain_en = 1'b1; chain_base = 40; chain_len = 2;
    run_collect(30, 3, 1'b0, 30, 1'b1);
    inj_cycle = -1; chain_en = 1'b0;
    tests_run++; if (done_cycle !== 6) begin tests_failed++; $display("FAIL b2b_run1_done got=%0d exp=6", done_cycle); end
    tests_run++; if (got_data.size() !== 3) begin tests_failed++; $display("FAIL b2b_run1_beats got=%0d exp=3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= got_data.size() || got_data[i] !== W'(130 + i) || i >= got_addr.size() || got_addr[i] !== 30 + i) begin
        tests_failed++; $display("FAIL b2b_run1_beat%0d got=%0d exp=%0d", i, (i < got_data.size()) ? int'(got_data[i]) : -1, 130 + i);
      end
    end
    tests_run++; if (busy_seen !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_busy got=%b exp=0", busy); end
    run_collect(0, 0, 1'b0, 30, 1'b0);
    tests_run++; if (first_read !== 1) begin tests_failed++; $display("FAIL b2b_run2_first_read got=%0d exp=1", first_read); end
    tests_run++; if (done_cycle !== 5) begin tests_failed++; $display("FAIL b2b_run2_done got=%0d exp=5", done_cycle); end
    tests_run++;
    if (got_data.size() !== 2 || got_data[0] !== W'(140) || got_data[1] !== W'(141) || got_addr.size() !== 2) begin
      tests_failed++; $display("FAIL b2b_run2_data got_n=%0d exp=2 (140,141)", got_data.size());
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = W'(i + 100);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side sequencer placed directly downstream of the cache BRAM.
- On a start pulse, reads a contiguous run of words (base address, length) through the BRAM's registered read port and emits them as a valid/ready stream to the compute datapath.
- Absorbs the BRAM's 1-cycle read latency with a credit-limited output FIFO, so backpressure never loses or duplicates data.

Parameters:
- DEPTH, 1024, words in the attached BRAM.
- WIDTH_BITS, 32, word width; matches the BRAM.
- FIFO_DEPTH, 2, output buffer entries; minimum 2, which gives full throughput.
- NBITS_ADDR, $clog2(DEPTH), derived; not to be overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  NBITS_ADDR  first word address; captured with start.
- length  in  NBITS_ADDR+1  word count, 0..DEPTH; captured with start.
- busy  out  1  high while in RUN or DRAIN.
- done  out  1  one-cycle completion pulse.
- bram_read_en  out  1  to BRAM read_en.
- bram_addr_read  out  NBITS_ADDR  to BRAM addr_read.
- bram_data_out  in  WIDTH_BITS  from BRAM data_out; valid the cycle after bram_read_en.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_data  out  WIDTH_BITS  stream data (FIFO head).
- m_last  out  1  marks the final word of the run.

Behaviour:
- Reset: the asynchronous path returns
  - the FSM to IDLE,
  - all counters, FIFO occupancy and the in-flight flag to 0.
- Reset values of outputs: busy=0, done=0, bram_read_en=0, bram_addr_read=0, m_valid=0, m_data=0, m_last=0.
- Reset mid-run: the run is abandoned and no further beats are emitted. A BRAM word still in flight is discarded, because the in-flight flag is cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when start=1 and length!=0; the edge latches addr=base_addr, issue_cnt=length, beat_cnt=length.
  - IDLE + start with length=0: no reads and no beats; done pulses on the next cycle.
  - RUN -> DRAIN when the last read has been issued (issue_cnt reaches 0).
  - DRAIN -> IDLE on the m_valid&&m_ready handshake with m_last=1.
  - start while busy is ignored.
- Read issue:
  - bram_read_en is driven combinationally and is 1 only in RUN when issue_cnt!=0 and (occupancy + inflight - pop) < FIFO_DEPTH, where pop = m_valid&&m_ready.
  - bram_addr_read = addr. On each issue, addr increments modulo DEPTH (wraps DEPTH-1 -> 0) and issue_cnt decrements.
- Capture: the in-flight flag registers bram_read_en. When it is set, bram_data_out is pushed into the FIFO on that edge.
  - A push and a pop in the same cycle keep occupancy unchanged.
  - The FIFO never overflows; this is guaranteed by the credit rule.
- Stream:
  - m_valid = FIFO not empty.
  - m_data is the FIFO head.
  - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
  - m_last = m_valid && beat_cnt==1.
  - beat_cnt decrements on each handshake.
- Latency and throughput:
  - Timeline: start in cycle 0, bram_read_en first in cycle 1, first m_valid in cycle 3.
  - With m_ready held high, one beat per cycle; a run of N words finishes its last handshake in cycle N+2.
- done: pulses in the cycle after the last handshake. busy is 0 in that cycle, and a new start is accepted in that same cycle.
- length=DEPTH: reads every word exactly once, starting at base_addr and wrapping.

Decomposition:
- Package bram_stream_pkg holds:
  - the state_e enum {IDLE, RUN, DRAIN};
  - the addr_t and len_t typedef helpers, parameterised by the NBITS_ADDR width.
- Sub-module stream_fifo, generic sync FIFO:
  - parameters WIDTH, DEPTH;
  - ports push, pop, din, dout, empty, count;
  - asynchronous active-high reset.
- The credit, address and FSM logic stay in the top module.

Test Plan:
- Preload ram[i]=i+100. start, base=4, length=5, m_ready=1 -> m_data 104..108 in cycles 3..7; m_last only on 108; done in cycle 8.
- base=DEPTH-2, length=4 -> addresses DEPTH-2, DEPTH-1, 0, 1; data ram[DEPTH-2], ram[DEPTH-1], 100, 101.
- length=6 with m_ready toggling 1,0,0,1,... and random stalls -> exactly 6 beats, in order; data held stable during stalls; occupancy never exceeds FIFO_DEPTH; bram_read_en never asserted while the credit rule is full.
- length=0 -> no bram_read_en, no m_valid; done=1 in the cycle after start; busy stays 0.
- reset=1 mid-run after 2 beats -> all outputs return to their reset values immediately (async); after release a new run base=0, length=3 produces exactly 100, 101, 102.
- start pulsed again while busy -> ignored; the original run completes unchanged; a start in the done cycle launches the next run.
